// File: rtl/pwm_audio_tone_mixer.sv
// Multi-channel square-wave tone synthesiser feeding a PWM DAC.
// The mix is sampled into the duty register once per PWM frame, so config writes never glitch a frame.
module pwm_audio_tone_mixer #(
    parameter int CHANNELS = 4,
    parameter int DIV_BITS = 12,
    parameter int VOL_BITS = 4,
    parameter int PWM_BITS = 8,
    localparam int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int MIX_BITS = VOL_BITS + $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                cfg_we,
    input  logic [CH_BITS-1:0]  cfg_ch,
    input  logic [DIV_BITS-1:0] cfg_div,
    input  logic [VOL_BITS-1:0] cfg_vol,
    output logic                pwm_out,
    output logic                frame_tick,
    output logic [MIX_BITS-1:0] mix_dbg
);

    localparam int SHIFT = PWM_BITS - MIX_BITS;
    localparam logic [CH_BITS:0] CH_LIMIT = (CH_BITS + 1)'(CHANNELS);

    logic [DIV_BITS-1:0] div_q [CHANNELS];
    logic [VOL_BITS-1:0] vol_q [CHANNELS];
    logic [DIV_BITS-1:0] cnt_q [CHANNELS];
    logic [CHANNELS-1:0] phase_q;
    logic [CHANNELS-1:0] wr_sel;
    logic                ch_valid;
    logic [MIX_BITS-1:0] mix;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] pwm_cnt_next;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_next;
    logic                frame_end;

    // Extra top bit lets non-power-of-two channel counts reject the unused indices.
    assign ch_valid = ({1'b0, cfg_ch} < CH_LIMIT);

    always_comb begin
        wr_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_sel[c] = cfg_we && ch_valid && (cfg_ch == CH_BITS'(c));
        end
    end

    // A write restarts the half-period count; a zero divider also parks the phase low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                div_q[c] <= '0;
                vol_q[c] <= '0;
                cnt_q[c] <= '0;
            end
            phase_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_sel[c]) begin
                    div_q[c] <= cfg_div;
                    vol_q[c] <= cfg_vol;
                    cnt_q[c] <= '0;
                    if (cfg_div == '0) begin
                        phase_q[c] <= 1'b0;
                    end
                end else if (ena) begin
                    if (div_q[c] == '0) begin
                        cnt_q[c]   <= '0;
                        phase_q[c] <= 1'b0;
                    end else if (cnt_q[c] == div_q[c]) begin
                        cnt_q[c]   <= '0;
                        phase_q[c] <= ~phase_q[c];
                    end else begin
                        cnt_q[c] <= cnt_q[c] + DIV_BITS'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        mix = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (phase_q[c]) begin
                mix = mix + MIX_BITS'(vol_q[c]);
            end
        end
    end

    assign frame_end    = (pwm_cnt == '1);
    assign pwm_cnt_next = pwm_cnt + PWM_BITS'(1);
    assign duty_next    = frame_end ? (PWM_BITS'(mix) << SHIFT) : duty;

    // Outputs are registered from next-state values so they line up with the counter they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt    <= '0;
            duty       <= '0;
            mix_dbg    <= '0;
            pwm_out    <= 1'b0;
            frame_tick <= 1'b0;
        end else if (ena) begin
            pwm_cnt    <= pwm_cnt_next;
            duty       <= duty_next;
            if (frame_end) begin
                mix_dbg <= mix;
            end
            pwm_out    <= (pwm_cnt_next < duty_next);
            frame_tick <= (pwm_cnt_next == '0);
        end else begin
            pwm_out    <= 1'b0;
            frame_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_audio_tone_mixer.sv
// Bench for pwm_audio_tone_mixer: a 4-channel and a 3-channel instance share one stimulus stream
// and are compared every cycle against a behavioural tone/frame model.
module tb_pwm_audio_tone_mixer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [11:0] cfg_div = '0;
    logic [3:0]  cfg_vol = '0;
    logic        pwm4, tick4, pwm3, tick3;
    logic [5:0]  mix4, mix3;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pwm_audio_tone_mixer dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_vol(cfg_vol), .pwm_out(pwm4), .frame_tick(tick4), .mix_dbg(mix4)
    );

    pwm_audio_tone_mixer #(.CHANNELS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_vol(cfg_vol), .pwm_out(pwm3), .frame_tick(tick3), .mix_dbg(mix3)
    );

    // Model: each tone holds its level for div+1 enabled cycles; a frame is 256 enabled cycles
    // whose high time equals 4x the mix present just before the frame starts.
    int m_div [2][8];
    int m_vol [2][8];
    int m_cnt [2][8];
    bit m_ph  [2][8];
    int m_duty [2];
    int m_mix  [2];
    bit m_pwm  [2];
    int m_pos;
    bit m_tick;
    int n_ch [2] = '{4, 3};
    int mix_now [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < 8; c++) begin
                    m_div[i][c] = 0;
                    m_vol[i][c] = 0;
                    m_cnt[i][c] = 0;
                    m_ph[i][c]  = 1'b0;
                end
                m_duty[i] = 0;
                m_mix[i]  = 0;
                m_pwm[i]  = 1'b0;
            end
            m_pos  = 0;
            m_tick = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                mix_now[i] = 0;
                for (int c = 0; c < n_ch[i]; c++) begin
                    if (m_ph[i][c]) mix_now[i] += m_vol[i][c];
                end
            end
            if (ena) begin
                if (m_pos == 255) begin
                    for (int i = 0; i < 2; i++) begin
                        m_duty[i] = mix_now[i] * 4;
                        m_mix[i]  = mix_now[i];
                    end
                end
                m_pos = (m_pos + 1) % 256;
            end
            m_tick = ena && (m_pos == 0);
            for (int i = 0; i < 2; i++) begin
                m_pwm[i] = ena && (m_pos < m_duty[i]);
                for (int c = 0; c < n_ch[i]; c++) begin
                    if (cfg_we && (int'(cfg_ch) == c)) begin
                        m_div[i][c] = int'(cfg_div);
                        m_vol[i][c] = int'(cfg_vol);
                        m_cnt[i][c] = 0;
                        if (cfg_div == 0) m_ph[i][c] = 1'b0;
                    end else if (ena && m_div[i][c] != 0) begin
                        if (m_cnt[i][c] == m_div[i][c]) begin
                            m_cnt[i][c] = 0;
                            m_ph[i][c]  = ~m_ph[i][c];
                        end else begin
                            m_cnt[i][c] += 1;
                        end
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        checkOutput("pwm_out4", 32'(pwm4), 32'(m_pwm[0]));
        checkOutput("frame_tick4", 32'(tick4), 32'(m_tick));
        checkOutput("mix_dbg4", 32'(mix4), 32'(m_mix[0]));
        checkOutput("pwm_out3", 32'(pwm3), 32'(m_pwm[1]));
        checkOutput("frame_tick3", 32'(tick3), 32'(m_tick));
        checkOutput("mix_dbg3", 32'(mix3), 32'(m_mix[1]));
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int ch, input int div, input int vol);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_div = 12'(div);
        cfg_vol = 4'(vol);
        step();
        cfg_we  = 1'b0;
    endtask

    task automatic wait_tick();
        for (int k = 0; k < 300; k++) begin
            step();
            if (tick4) return;
        end
        checkOutput("frame_tick_timeout", 0, 1);
    endtask

    task automatic measure_frame(output int hi, output int md);
        wait_tick();
        md = int'(mix4);
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            hi += int'(pwm4);
            step();
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int hi, md, ticks, sel;

    initial begin
        // Idle after reset: silent output, one tick per 256 cycles.
        step(3);
        @(negedge clk);
        rst_n = 1'b1;
        ticks = 0;
        hi = 0;
        for (int k = 0; k < 1024; k++) begin
            step();
            ticks += int'(tick4);
            hi += int'(pwm4);
        end
        checkOutput("idle_ticks", ticks, 4);
        checkOutput("idle_high", hi, 0);
        checkOutput("idle_mix", 32'(mix4), 0);

        // Single fast tone: each frame is either silent or 60 cycles high.
        applyStimulus(0, 3, 15);
        for (int f = 0; f < 3; f++) begin
            measure_frame(hi, md);
            checkOutput("tone_frame", 32'((hi == 60 && md == 15) || (hi == 0 && md == 0)), 1);
        end

        // All channels full volume and in phase.
        for (int c = 0; c < 4; c++) applyStimulus(c, 0, 0);
        for (int c = 0; c < 4; c++) applyStimulus(c, 1000, 15);
        step(1005);
        measure_frame(hi, md);
        checkOutput("full_high", hi, 240);
        checkOutput("full_mix", md, 60);
        checkOutput("full_mix3", 32'(mix3), 45);

        // Volume change mid-frame only affects the following frame.
        for (int c = 1; c < 4; c++) applyStimulus(c, 0, 0);
        applyStimulus(0, 1000, 15);
        wait_tick();
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            hi += int'(pwm4);
            if (k == 100) begin
                cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 12'd1000; cfg_vol = 4'd5;
            end
            step();
            cfg_we = 1'b0;
        end
        checkOutput("vol_cur_frame", hi, 60);
        checkOutput("vol_next_tick", 32'(tick4), 1);
        checkOutput("vol_next_mix", 32'(mix4), 5);
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            hi += int'(pwm4);
            step();
        end
        checkOutput("vol_next_frame", hi, 20);

        // Zero divider silences a high channel; index 3 is out of range for the 3-channel instance.
        applyStimulus(0, 0, 5);
        measure_frame(hi, md);
        checkOutput("silence_high", hi, 0);
        checkOutput("silence_mix", md, 0);
        applyStimulus(3, 3, 15);
        for (int f = 0; f < 2; f++) begin
            measure_frame(hi, md);
            checkOutput("ch3_frame", 32'((hi == 60 && md == 15) || (hi == 0 && md == 0)), 1);
            checkOutput("ch3_ignored", 32'(mix3), 0);
        end

        // Enable pause mid-tone, then asynchronous reset while the output is high.
        applyStimulus(3, 0, 0);
        applyStimulus(0, 1000, 15);
        step(600);
        ena = 1'b0;
        hi = 0;
        ticks = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            hi += int'(pwm4);
            ticks += int'(tick4);
        end
        checkOutput("pause_high", hi, 0);
        checkOutput("pause_ticks", ticks, 0);
        ena = 1'b1;
        step(500);
        wait_tick();
        step(10);
        checkOutput("pre_reset_pwm", 32'(pwm4), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_pwm", 32'(pwm4), 0);
        checkOutput("async_reset_mix", 32'(mix4), 0);
        step(3);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic.
        for (int k = 0; k < 4000; k++) begin
            cfg_we  = ($urandom_range(0, 99) < 12);
            cfg_ch  = 2'($urandom);
            cfg_vol = 4'($urandom);
            sel = $urandom_range(0, 3);
            case (sel)
                0:       cfg_div = 12'd0;
                1:       cfg_div = 12'($urandom_range(1, 7));
                2:       cfg_div = 12'($urandom_range(8, 100));
                default: cfg_div = 12'($urandom);
            endcase
            ena = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 1499) == 0) pulse_reset();
            step();
        end
        cfg_we = 1'b0;
        ena = 1'b1;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
